// File: rtl/kuznechik_pkg.sv
// Kuznechik primitives: S-box, GF(2^8) arithmetic, linear layer L and its inverse, key-schedule constants.
// Latency: purely combinational functions.
// Backpressure: none; consumed by the round and core modules.
package kuznechik_pkg;

    typedef logic [127:0] block_t;
    typedef logic [255:0] key_t;

    // Nonlinear bijection pi; the inverse S-box is found by searching this table
    localparam logic [7:0] PI [256] = '{
        8'hFC, 8'hEE, 8'hDD, 8'h11, 8'hCF, 8'h6E, 8'h31, 8'h16, 8'hFB, 8'hC4, 8'hFA, 8'hDA, 8'h23, 8'hC5, 8'h04, 8'h4D,
        8'hE9, 8'h77, 8'hF0, 8'hDB, 8'h93, 8'h2E, 8'h99, 8'hBA, 8'h17, 8'h36, 8'hF1, 8'hBB, 8'h14, 8'hCD, 8'h5F, 8'hC1,
        8'hF9, 8'h18, 8'h65, 8'h5A, 8'hE2, 8'h5C, 8'hEF, 8'h21, 8'h81, 8'h1C, 8'h3C, 8'h42, 8'h8B, 8'h01, 8'h8E, 8'h4F,
        8'h05, 8'h84, 8'h02, 8'hAE, 8'hE3, 8'h6A, 8'h8F, 8'hA0, 8'h06, 8'h0B, 8'hED, 8'h98, 8'h7F, 8'hD4, 8'hD3, 8'h1F,
        8'hEB, 8'h34, 8'h2C, 8'h51, 8'hEA, 8'hC8, 8'h48, 8'hAB, 8'hF2, 8'h2A, 8'h68, 8'hA2, 8'hFD, 8'h3A, 8'hCE, 8'hCC,
        8'hB5, 8'h70, 8'h0E, 8'h56, 8'h08, 8'h0C, 8'h76, 8'h12, 8'hBF, 8'h72, 8'h13, 8'h47, 8'h9C, 8'hB7, 8'h5D, 8'h87,
        8'h15, 8'hA1, 8'h96, 8'h29, 8'h10, 8'h7B, 8'h9A, 8'hC7, 8'hF3, 8'h91, 8'h78, 8'h6F, 8'h9D, 8'h9E, 8'hB2, 8'hB1,
        8'h32, 8'h75, 8'h19, 8'h3D, 8'hFF, 8'h35, 8'h8A, 8'h7E, 8'h6D, 8'h54, 8'hC6, 8'h80, 8'hC3, 8'hBD, 8'h0D, 8'h57,
        8'hDF, 8'hF5, 8'h24, 8'hA9, 8'h3E, 8'hA8, 8'h43, 8'hC9, 8'hD7, 8'h79, 8'hD6, 8'hF6, 8'h7C, 8'h22, 8'hB9, 8'h03,
        8'hE0, 8'h0F, 8'hEC, 8'hDE, 8'h7A, 8'h94, 8'hB0, 8'hBC, 8'hDC, 8'hE8, 8'h28, 8'h50, 8'h4E, 8'h33, 8'h0A, 8'h4A,
        8'hA7, 8'h97, 8'h60, 8'h73, 8'h1E, 8'h00, 8'h62, 8'h44, 8'h1A, 8'hB8, 8'h38, 8'h82, 8'h64, 8'h9F, 8'h26, 8'h41,
        8'hAD, 8'h45, 8'h46, 8'h92, 8'h27, 8'h5E, 8'h55, 8'h2F, 8'h8C, 8'hA3, 8'hA5, 8'h7D, 8'h69, 8'hD5, 8'h95, 8'h3B,
        8'h07, 8'h58, 8'hB3, 8'h40, 8'h86, 8'hAC, 8'h1D, 8'hF7, 8'h30, 8'h37, 8'h6B, 8'hE4, 8'h88, 8'hD9, 8'hE7, 8'h89,
        8'hE1, 8'h1B, 8'h83, 8'h49, 8'h4C, 8'h3F, 8'hF8, 8'hFE, 8'h8D, 8'h53, 8'hAA, 8'h90, 8'hCA, 8'hD8, 8'h85, 8'h61,
        8'h20, 8'h71, 8'h67, 8'hA4, 8'h2D, 8'h2B, 8'h09, 8'h5B, 8'hCB, 8'h9B, 8'h25, 8'hD0, 8'hBE, 8'hE5, 8'h6C, 8'h52,
        8'h59, 8'hA6, 8'h74, 8'hD2, 8'hE6, 8'hF4, 8'hB4, 8'hC0, 8'hD1, 8'h66, 8'hAF, 8'hC2, 8'h39, 8'h4B, 8'h63, 8'hB6
    };

    // Coefficients of l(), applied to bytes 15 down to 0
    localparam logic [7:0] L_COEF [16] = '{
        8'd148, 8'd32, 8'd133, 8'd16, 8'd194, 8'd192, 8'd1, 8'd251,
        8'd1, 8'd192, 8'd194, 8'd16, 8'd133, 8'd32, 8'd148, 8'd1
    };

    // Multiply in GF(2^8) modulo x^8+x^7+x^6+x+1
    function automatic logic [7:0] gf_mul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p;
        logic [7:0] s;
        p = '0;
        s = x;
        for (int i = 0; i < 8; i++) begin
            if (y[i]) p = p ^ s;
            s = s[7] ? ((s << 1) ^ 8'hC3) : (s << 1);
        end
        return p;
    endfunction

    // Linear combination of all 16 bytes (byte 15 is the top byte)
    function automatic logic [7:0] l_byte(input block_t d);
        logic [7:0] acc;
        acc = '0;
        for (int k = 0; k < 16; k++)
            acc = acc ^ gf_mul(d[8*(15-k) +: 8], L_COEF[k]);
        return acc;
    endfunction

    // L: sixteen R steps, each shifting down one byte and inserting l() on top
    function automatic block_t lin(input block_t d);
        block_t v;
        v = d;
        for (int i = 0; i < 16; i++)
            v = {l_byte(v), v[127:8]};
        return v;
    endfunction

    // L^-1: rotate up one byte, then recover the bottom byte through l()
    function automatic block_t lin_inv(input block_t d);
        block_t v;
        v = d;
        for (int i = 0; i < 16; i++) begin
            v = {v[119:0], v[127:120]};
            v[7:0] = l_byte(v);
        end
        return v;
    endfunction

    function automatic block_t sub(input block_t d);
        block_t v;
        for (int i = 0; i < 16; i++)
            v[8*i +: 8] = PI[d[8*i +: 8]];
        return v;
    endfunction

    function automatic block_t sub_inv(input block_t d);
        block_t v;
        v = '0;
        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 256; j++)
                if (PI[j] == d[8*i +: 8]) v[8*i +: 8] = 8'(j);
        return v;
    endfunction

    // Key-schedule constant C_i = L(i)
    function automatic block_t iter_c(input logic [5:0] i);
        return lin({122'd0, i});
    endfunction

endpackage

// File: rtl/kuznechik_round.sv
// One Kuznechik round: forward L(S(d^k)) or inverse Sinv(Linv(d))^k.
// Latency: combinational.
// Backpressure: none; the enclosing core sequences rounds.
module kuznechik_round
    import kuznechik_pkg::*;
#(
    parameter int DECRYPT_EN = 1
) (
    input  logic [127:0] data,
    input  logic [127:0] rkey,
    input  logic         inv,
    output logic [127:0] result
);

    if (DECRYPT_EN != 0) begin : g_dec
        assign result = inv ? (sub_inv(lin_inv(data)) ^ rkey) : lin(sub(data ^ rkey));
    end else begin : g_enc
        logic unused_inv;
        assign unused_inv = inv;
        assign result = lin(sub(data ^ rkey));
    end

endmodule

// File: rtl/kuznechik_iter_core.sv
// Iterative Kuznechik core with on-chip key expansion, one block in flight.
// Latency: key accept to keys_ok 33 clocks; block accept to out_valid 9/ROUNDS_PER_CYCLE+1 clocks.
// Backpressure: result held in HOLD until out_ready; key_ready/in_ready low outside IDLE.
module kuznechik_iter_core
    import kuznechik_pkg::*;
#(
    parameter int ROUNDS_PER_CYCLE = 1,
    parameter int DECRYPT_EN       = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [255:0] key,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_block,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_block,
    output logic         keys_ok
);

    typedef enum logic [1:0] {ST_IDLE, ST_KEYGEN, ST_RUN, ST_HOLD} state_t;

    localparam logic [4:0] LAST = 5'(9 / ROUNDS_PER_CYCLE - 1);

    state_t       state;
    logic [4:0]   cnt;
    logic [127:0] a;        // cipher state, or a1 of the key-schedule Feistel pair
    logic [127:0] b;        // a0 of the key-schedule Feistel pair
    logic         mode_q;
    logic [127:0] rk [10];  // K1..K10
    logic [3:0]   kidx;
    logic         mode_eff;
    logic         rnd_inv;
    logic [127:0] round0;
    logic [127:0] chain_last;

    assign key_ready = (state == ST_IDLE) && !rst;
    assign in_ready  = key_ready && keys_ok && !key_valid;
    assign mode_eff  = mode && (DECRYPT_EN != 0);
    assign rnd_inv   = (state == ST_RUN) && mode_q;
    assign kidx      = {1'b0, cnt[4:3], 1'b0} + 4'd2;

    for (genvar g = 0; g < ROUNDS_PER_CYCLE; g++) begin : g_rnd
        logic [127:0] din;
        logic [127:0] rkey;
        logic [127:0] dout;

        if (g == 0) begin : g_first
            assign din = a;
        end else begin : g_next
            assign din = g_rnd[g-1].dout;
        end

        // Round key for this stage: K_n forward, K_(10-n) inverse, C_i while expanding keys
        always_comb begin
            rkey = '0;
            for (int r = 0; r < 9; r++)
                if (int'(cnt) * ROUNDS_PER_CYCLE + g == (mode_q ? 8 - r : r)) rkey = rk[r];
            if (g == 0 && state == ST_KEYGEN) rkey = iter_c({1'b0, cnt} + 6'd1);
        end

        kuznechik_round #(.DECRYPT_EN(DECRYPT_EN)) u_round (
            .data   (din),
            .rkey   (rkey),
            .inv    (rnd_inv),
            .result (dout)
        );
    end

    assign round0     = g_rnd[0].dout;
    assign chain_last = g_rnd[ROUNDS_PER_CYCLE-1].dout;

    // Control FSM, key expansion, block iteration and result register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            a         <= '0;
            b         <= '0;
            mode_q    <= 1'b0;
            keys_ok   <= 1'b0;
            out_valid <= 1'b0;
            out_block <= '0;
            for (int i = 0; i < 10; i++) rk[i] <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (key_valid) begin
                        rk[0]   <= key[255:128];
                        rk[1]   <= key[127:0];
                        a       <= key[255:128];
                        b       <= key[127:0];
                        keys_ok <= 1'b0;
                        cnt     <= '0;
                        state   <= ST_KEYGEN;
                    end else if (in_valid && keys_ok) begin
                        // decryption starts with the K10 whitening
                        a      <= in_block ^ (mode_eff ? rk[9] : '0);
                        mode_q <= mode_eff;
                        cnt    <= '0;
                        state  <= ST_RUN;
                    end
                end
                ST_KEYGEN: begin
                    a <= round0 ^ b;
                    b <= a;
                    if (cnt[2:0] == 3'd7) begin
                        rk[kidx]        <= round0 ^ b;
                        rk[kidx + 4'd1] <= a;
                    end
                    if (cnt == 5'd31) begin
                        keys_ok <= 1'b1;
                        state   <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_RUN: begin
                    a <= chain_last;
                    if (cnt == LAST) begin
                        out_block <= mode_q ? chain_last : (chain_last ^ rk[9]);
                        out_valid <= 1'b1;
                        state     <= ST_HOLD;
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_kuznechik_iter_core.sv
// Bench for kuznechik_iter_core: known-answer table, handshake corner cases, randomized blocks vs a reference model.
// Latency: checks 33-clock key expansion and 9/R+1-clock block latency.
// Backpressure: exercises held results, refused keys/blocks and reset mid-operation.
module tb_kuznechik_iter_core;

    localparam int R   = 1;
    localparam int LAT = 9 / R + 1;
    localparam int COEF [16] = '{148, 32, 133, 16, 194, 192, 1, 251, 1, 192, 194, 16, 133, 32, 148, 1};

    localparam logic [255:0] KEY1 = 256'h8899aabbccddeeff0011223344556677fedcba98765432100123456789abcdef;
    localparam logic [127:0] PT   = 128'h1122334455667700ffeeddccbbaa9988;
    localparam logic [127:0] CT   = 128'h7f679d90bebc24305a468d42b9d4edcd;
    localparam logic [127:0] K3   = 128'hdb31485315694343228d6aef8cc78c44;
    localparam logic [127:0] K10  = 128'h72e9dd7416bcf45b755dbaa88e4a4043;

    logic         clk = 1'b0;
    logic         rst;
    logic         key_valid, key_ready;
    logic [255:0] key;
    logic         in_valid, in_ready;
    logic [127:0] in_block;
    logic         mode;
    logic         out_valid, out_ready;
    logic [127:0] out_block;
    logic         keys_ok;

    int n_cmp = 0;
    int n_err = 0;

    logic [127:0] mk [10];

    typedef struct {
        logic         md;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    vec_t tbl [4];

    kuznechik_iter_core #(.ROUNDS_PER_CYCLE(R), .DECRYPT_EN(1)) dut (
        .clk       (clk),
        .rst       (rst),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key       (key),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block),
        .keys_ok   (keys_ok)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // ---------------- reference model: byte arrays and plain polynomial arithmetic ----------------
    function automatic int m_mul(input int x, input int y);
        int p = 0;
        for (int i = 0; i < 8; i++) if (y[i]) p = p ^ (x << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h1C3 << (i - 8));
        return p;
    endfunction

    function automatic logic [127:0] m_l(input logic [127:0] v);
        int x [16];
        int t;
        logic [127:0] r;
        for (int k = 0; k < 16; k++) x[k] = int'(v[8*(15-k) +: 8]);
        for (int s = 0; s < 16; s++) begin
            t = 0;
            for (int k = 0; k < 16; k++) t = t ^ m_mul(COEF[k], x[k]);
            for (int k = 15; k > 0; k--) x[k] = x[k-1];
            x[0] = t;
        end
        for (int k = 0; k < 16; k++) r[8*(15-k) +: 8] = 8'(x[k]);
        return r;
    endfunction

    function automatic logic [127:0] m_s(input logic [127:0] v);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = kuznechik_pkg::PI[v[8*k +: 8]];
        return r;
    endfunction

    task automatic m_expand(input logic [255:0] k);
        logic [127:0] a1, a0, t;
        a1 = k[255:128];
        a0 = k[127:0];
        mk[0] = a1;
        mk[1] = a0;
        for (int i = 1; i <= 32; i++) begin
            t  = m_l(m_s(a1 ^ m_l(128'(i)))) ^ a0;
            a0 = a1;
            a1 = t;
            if (i % 8 == 0) begin
                mk[i / 4]     = a1;
                mk[i / 4 + 1] = a0;
            end
        end
    endtask

    function automatic logic [127:0] m_enc(input logic [127:0] p);
        logic [127:0] v;
        v = p;
        for (int i = 0; i < 9; i++) v = m_l(m_s(v ^ mk[i]));
        return v ^ mk[9];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- drivers ----------------
    task automatic load_key(input logic [255:0] k);
        int n = 0;
        key = k;
        key_valid = 1'b1;
        #1;
        while (!key_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("key_ready wait", key_ready, 1);
        @(posedge clk); #1;
        key_valid = 1'b0;
        key = '0;
        chk("keygen busy {keys_ok,key_ready,in_ready}", {keys_ok, key_ready, in_ready}, 3'b000);
        n = 1;
        while (!keys_ok && n < 200) begin @(posedge clk); #1; n++; end
        chk("keygen latency", n, 33);
    endtask

    task automatic run_block(input logic m, input logic [127:0] din, output logic [127:0] dout, output int lat);
        int t = 0;
        mode = m;
        in_block = din;
        in_valid = 1'b1;
        #1;
        while (!in_ready && t < 200) begin @(posedge clk); #1; t++; end
        chk("in_ready wait", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_block = '0;
        mode = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        dout = out_block;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    initial begin
        logic [127:0] got, p, c;
        logic [255:0] key2;
        int lat;
        int n;
        logic bad;

        rst = 1'b1; key_valid = 1'b0; key = '0; in_valid = 1'b0; in_block = '0; mode = 1'b0; out_ready = 1'b0;

        // reset state
        #1;
        chk("reset {key_ready,in_ready,out_valid,keys_ok}", {key_ready, in_ready, out_valid, keys_ok}, 4'b0000);
        chk("reset out_block", out_block, '0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("idle no key {key_ready,in_ready}", {key_ready, in_ready}, 2'b10);

        // T1 key expansion
        m_expand(KEY1);
        load_key(KEY1);
        chk("K3", dut.rk[2], K3);
        chk("K10", dut.rk[9], K10);
        for (int i = 0; i < 10; i++) chk($sformatf("round key %0d", i + 1), dut.rk[i], mk[i]);

        // T2/T3 and more, table-driven
        tbl[0] = '{1'b0, PT, CT};
        tbl[1] = '{1'b1, CT, PT};
        tbl[2] = '{1'b0, 128'd0, m_enc(128'd0)};
        tbl[3] = '{1'b1, m_enc({128{1'b1}}), {128{1'b1}}};
        for (int i = 0; i < 4; i++) begin
            run_block(tbl[i].md, tbl[i].din, got, lat);
            chk($sformatf("table %0d result", i), got, tbl[i].dout);
            chk($sformatf("table %0d latency", i), lat, LAT);
            consume();
        end

        // T4 backpressure with a key offered while the result is held
        run_block(1'b0, PT, got, lat);
        key_valid = 1'b1;
        key = {rnd128(), rnd128()};
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("hold %0d {out_valid,in_ready,key_ready}", i), {out_valid, in_ready, key_ready}, 3'b100);
            chk($sformatf("hold %0d out_block", i), out_block, CT);
            @(posedge clk); #1;
        end
        key_valid = 1'b0;
        consume();
        chk("after drain {out_valid,in_ready,key_ready}", {out_valid, in_ready, key_ready}, 3'b011);
        run_block(1'b1, CT, got, lat);
        chk("key kept through hold", got, PT);
        consume();

        // T5 key and block offered together
        key2 = {rnd128(), rnd128()};
        p = rnd128();
        key = key2; key_valid = 1'b1;
        in_block = p; mode = 1'b0; in_valid = 1'b1;
        #1;
        chk("T5 {key_ready,in_ready}", {key_ready, in_ready}, 2'b10);
        @(posedge clk); #1;
        key_valid = 1'b0;
        n = 1;
        chk("T5 keys_ok dropped", keys_ok, 0);
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk("T5 in_ready after keygen", n, 33);
        chk("T5 no early result", out_valid, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        m_expand(key2);
        chk("T5 result under new key", out_block, m_enc(p));
        consume();

        // randomized round trips against the model
        for (int i = 0; i < 10; i++) begin
            p = rnd128();
            run_block(1'b0, p, c, lat);
            chk($sformatf("rand %0d encrypt", i), c, m_enc(p));
            repeat ($urandom_range(0, 3)) @(posedge clk);
            consume();
            run_block(1'b1, c, got, lat);
            chk($sformatf("rand %0d decrypt", i), got, p);
            chk($sformatf("rand %0d latency", i), lat, LAT);
            consume();
        end

        // T6 reset pulse in the middle of RUN
        mode = 1'b0; in_block = rnd128(); in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("T6 in reset {out_valid,keys_ok,in_ready,key_ready}", {out_valid, keys_ok, in_ready, key_ready}, 4'b0000);
        @(posedge clk); #1 rst = 1'b0;
        chk("T6 key regs cleared", dut.rk[9], '0);
        p = rnd128();
        in_block = p; in_valid = 1'b1;
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (out_valid || in_ready) bad = 1'b1;
        end
        chk("T6 no activity without key", bad, 0);
        load_key(KEY1);
        m_expand(KEY1);
        run_block(1'b0, p, got, lat);
        chk("T6 result after reload", got, m_enc(p));
        consume();
        run_block(1'b0, PT, got, lat);
        chk("T6 known answer after reload", got, CT);
        consume();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
